// File: rtl/alu_pwr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pwr_pkg
// Description : Shared types and helpers for the ALU power sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pwr_pkg;

  // Width of the observable state encoding.
  localparam int PWR_STATE_W = 3;

  // Sequencer states; unused codes are illegal and recover to OFF.
  typedef enum logic [PWR_STATE_W-1:0] {
    OFF    = 3'd0,
    RAMP   = 3'd1,
    ON     = 3'd2,
    ISO_ON = 3'd3
  } pwr_state_t;

  // A zero-length wait phase is stretched to one cycle.
  function automatic int eff_cycles(input int cyc);
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwr_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : pwr_seq_timer
// Description : Loadable down-counter that stops at zero; shared by the
//               isolation-setup and power-up wait phases.
// Revision    : 1.0 - initial release
// ============================================================================
module pwr_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load on request, otherwise count down and hold at zero (never wraps).
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/alu_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_pwr_seq
// Description : Power-sequencing controller for the power-gated ALU. Orders
//               isolation and power-switch control so that isolation always
//               covers any period where power is off or settling.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pwr_seq
  import alu_pwr_pkg::*;
#(
  parameter int ISO_SETUP_CYC = 2,
  parameter int PWR_UP_CYC    = 4,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sleep_req,
  input  logic                   wake_req,
  input  logic                   alu_busy,
  output logic                   alu_pwr_en,
  output logic                   iso_en,
  output logic                   alu_ready,
  output logic                   sleep_done,
  output logic                   wake_done,
  output logic [PWR_STATE_W-1:0] pwr_state
);

  localparam int ISO_EFF = eff_cycles(ISO_SETUP_CYC);
  localparam int PWR_EFF = eff_cycles(PWR_UP_CYC);

  // The counter must be able to hold the longest phase length minus one.
  generate
    if ((longint'(ISO_EFF) >= (longint'(1) << CNT_W)) ||
        (longint'(PWR_EFF) >= (longint'(1) << CNT_W))) begin : g_cnt_w_check
      $error("alu_pwr_seq: CNT_W too small for ISO_SETUP_CYC/PWR_UP_CYC");
    end
  endgenerate

  // Counter ends a phase on its last cycle, so it is loaded with length-1.
  localparam logic [CNT_W-1:0] ISO_LOAD = CNT_W'(ISO_EFF - 1);
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWR_EFF - 1);

  pwr_state_t       state_q;
  pwr_state_t       state_d;
  logic             sleep_done_q;
  logic             sleep_done_d;
  logic             wake_done_q;
  logic             wake_done_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;

  pwr_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  // Next-state logic; wait phases are committed and ignore requests.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      OFF: begin
        if (wake_req) begin
          state_d      = RAMP;
          tmr_load     = 1'b1;
          tmr_load_val = PWR_LOAD;
        end
      end
      RAMP: begin
        if (tmr_zero) begin
          state_d = ON;
        end
      end
      ON: begin
        // Never start isolating while an ALU operation is in flight;
        // a concurrent wake request cancels the sleep.
        if (sleep_req && !wake_req && !alu_busy) begin
          state_d      = ISO_ON;
          tmr_load     = 1'b1;
          tmr_load_val = ISO_LOAD;
        end
      end
      ISO_ON: begin
        if (tmr_zero) begin
          state_d = OFF;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
    sleep_done_d = (state_q == ISO_ON) && (state_d == OFF);
    wake_done_d  = (state_q == RAMP)   && (state_d == ON);
  end

  // State and completion-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OFF;
      sleep_done_q <= 1'b0;
      wake_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sleep_done_q <= sleep_done_d;
      wake_done_q  <= wake_done_d;
    end
  end

  // Moore output decode from the state register; illegal codes look like OFF.
  always_comb begin
    alu_pwr_en = 1'b0;
    iso_en     = 1'b1;
    alu_ready  = 1'b0;
    unique case (state_q)
      RAMP:    alu_pwr_en = 1'b1;
      ON: begin
        alu_pwr_en = 1'b1;
        iso_en     = 1'b0;
        alu_ready  = 1'b1;
      end
      ISO_ON:  alu_pwr_en = 1'b1;
      default: alu_pwr_en = 1'b0;
    endcase
  end

  assign sleep_done = sleep_done_q;
  assign wake_done  = wake_done_q;
  assign pwr_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pwr_seq
// Description : Directed self-checking bench for alu_pwr_seq (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pwr_seq;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       sleep_req = 1'b0;
  logic       wake_req  = 1'b0;
  logic       alu_busy  = 1'b0;
  logic       alu_pwr_en;
  logic       iso_en;
  logic       alu_ready;
  logic       sleep_done;
  logic       wake_done;
  logic [2:0] pwr_state;

  int total = 0;
  int bad   = 0;

  // Observed vector: {pwr_en, iso, ready, sleep_done, wake_done, state[2:0]}
  wire [7:0] obs = {alu_pwr_en, iso_en, alu_ready, sleep_done, wake_done, pwr_state};

  localparam logic [7:0] E_OFF    = 8'b0100_0000;
  localparam logic [7:0] E_OFF_SD = 8'b0101_0000;
  localparam logic [7:0] E_RAMP   = 8'b1100_0001;
  localparam logic [7:0] E_ON     = 8'b1010_0010;
  localparam logic [7:0] E_ON_WD  = 8'b1010_1010;
  localparam logic [7:0] E_ISO    = 8'b1100_0011;

  alu_pwr_seq #(
    .ISO_SETUP_CYC (2),
    .PWR_UP_CYC    (4),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sleep_req  (sleep_req),
    .wake_req   (wake_req),
    .alu_busy   (alu_busy),
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .alu_ready  (alu_ready),
    .sleep_done (sleep_done),
    .wake_done  (wake_done),
    .pwr_state  (pwr_state)
  );

  always #5 clk = ~clk;

  // Safety monitor: never unpowered-and-unisolated, never both switch together.
  logic prev_pwr = 1'b0;
  logic prev_iso = 1'b1;
  logic prev_rst = 1'b0;
  always @(negedge clk) begin
    total++;
    if (!alu_pwr_en && !iso_en) begin
      bad++;
      $display("FAIL monitor_iso_pwr t=%0t pwr_en=%b iso_en=%b required not both 0",
               $time, alu_pwr_en, iso_en);
    end
    if (rst_n && prev_rst) begin
      total++;
      if ((alu_pwr_en !== prev_pwr) && (iso_en !== prev_iso)) begin
        bad++;
        $display("FAIL monitor_same_cycle t=%0t pwr %b->%b iso %b->%b required not both changing",
                 $time, prev_pwr, alu_pwr_en, prev_iso, iso_en);
      end
    end
    prev_pwr = alu_pwr_en;
    prev_iso = iso_en;
    prev_rst = rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (obs !== E_OFF) begin
      bad++;
      $display("FAIL reset_held got=%b want=%b", obs, E_OFF);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (obs !== E_OFF) begin
        bad++;
        $display("FAIL reset_idle[%0d] got=%b want=%b", i, obs, E_OFF);
      end
    end
  endtask

  task automatic test_wake();
    logic [7:0] exp_seq [7] = '{E_RAMP, E_RAMP, E_RAMP, E_RAMP, E_ON_WD, E_ON, E_ON};
    wake_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      wake_req = 1'b0;
      total++;
      if (obs !== exp_seq[i]) begin
        bad++;
        $display("FAIL wake_seq edge%0d got=%b want=%b", i + 1, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_sleep_busy();
    logic [7:0] exp_seq [4] = '{E_ISO, E_ISO, E_OFF_SD, E_OFF};
    sleep_req = 1'b1;
    alu_busy  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (obs !== E_ON) begin
        bad++;
        $display("FAIL sleep_busy_hold[%0d] got=%b want=%b", i, obs, E_ON);
      end
    end
    alu_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) sleep_req = 1'b0;
      total++;
      if (obs !== exp_seq[i]) begin
        bad++;
        $display("FAIL sleep_after_busy[%0d] got=%b want=%b", i, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_sleep_wake_both();
    logic [7:0] exp_seq [4] = '{E_ISO, E_ISO, E_OFF_SD, E_OFF};
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    repeat (5) step();
    total++;
    if (obs !== E_ON) begin
      bad++;
      $display("FAIL both_setup_on got=%b want=%b", obs, E_ON);
    end
    sleep_req = 1'b1;
    wake_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (obs !== E_ON) begin
        bad++;
        $display("FAIL both_stay_on[%0d] got=%b want=%b", i, obs, E_ON);
      end
    end
    wake_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) sleep_req = 1'b0;
      total++;
      if (obs !== exp_seq[i]) begin
        bad++;
        $display("FAIL both_then_sleep[%0d] got=%b want=%b", i, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [16] = '{E_RAMP, E_RAMP, E_RAMP, E_RAMP, E_ON_WD,
                                 E_ISO, E_ISO, E_OFF_SD,
                                 E_RAMP, E_RAMP, E_RAMP, E_RAMP, E_ON_WD,
                                 E_ISO, E_ISO, E_OFF_SD};
    wake_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      total++;
      if (obs !== exp_seq[i]) begin
        bad++;
        $display("FAIL back_to_back[%0d] got=%b want=%b", i, obs, exp_seq[i]);
      end
      if (exp_seq[i] == E_ON_WD) begin
        sleep_req = 1'b1;
        wake_req  = 1'b0;
      end else if (exp_seq[i] == E_ISO) begin
        sleep_req = 1'b0;
        wake_req  = 1'b1;
      end
    end
    wake_req  = 1'b0;
    sleep_req = 1'b0;
    step();
    total++;
    if (obs !== E_OFF) begin
      bad++;
      $display("FAIL back_to_back_end got=%b want=%b", obs, E_OFF);
    end
  endtask

  task automatic test_async_reset();
    // Reset in the second RAMP cycle.
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    step();
    total++;
    if (obs !== E_RAMP) begin
      bad++;
      $display("FAIL arst_ramp_setup got=%b want=%b", obs, E_RAMP);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== E_OFF) begin
      bad++;
      $display("FAIL arst_ramp_async got=%b want=%b", obs, E_OFF);
    end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (obs !== E_OFF) begin
      bad++;
      $display("FAIL arst_ramp_after got=%b want=%b", obs, E_OFF);
    end
    // Reset in the first ISO_ON cycle.
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    repeat (5) step();
    sleep_req = 1'b1;
    step();
    sleep_req = 1'b0;
    total++;
    if (obs !== E_ISO) begin
      bad++;
      $display("FAIL arst_iso_setup got=%b want=%b", obs, E_ISO);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== E_OFF) begin
      bad++;
      $display("FAIL arst_iso_async got=%b want=%b", obs, E_OFF);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== E_OFF) begin
        bad++;
        $display("FAIL arst_iso_after[%0d] got=%b want=%b", i, obs, E_OFF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_sleep_busy();
    test_sleep_wake_both();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
